// File: rtl/rc4_pkg.sv
// Shared types and defaults for the RC4 encrypt datapath: FSM state encoding,
// message/key sizing and the key-byte selector used during key scheduling.
package rc4_pkg;

   localparam int MSG_LEN_DEFAULT   = 32;
   localparam int KEY_BYTES_DEFAULT = 3;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_INIT,
      ST_KSA_RD_I,
      ST_KSA_GET_I,
      ST_KSA_GET_J,
      ST_KSA_WR_I,
      ST_KSA_WR_J,
      ST_PR_RD_I,
      ST_PR_GET_I,
      ST_PR_GET_J,
      ST_PR_WR_I,
      ST_PR_WR_J,
      ST_PR_RD_F,
      ST_PR_GET_F,
      ST_DONE
   } state_t;

   // Byte 0 is the most significant byte of the 24-bit key.
   function automatic logic [7:0] key_byte(input logic [23:0] key24, input logic [1:0] idx);
      case (idx)
         2'd0:    return key24[23:16];
         2'd1:    return key24[15:8];
         default: return key24[7:0];
      endcase
   endfunction

endpackage

// File: rtl/rc4_encryptor.sv
// RC4 encryptor: fills the shared S RAM, runs the key schedule, then streams
// MSG_LEN keystream-xor-plaintext bytes into the ciphertext RAM.
module rc4_encryptor
   import rc4_pkg::*;
#(
   parameter int MSG_LEN   = MSG_LEN_DEFAULT,
   parameter int KEY_BYTES = KEY_BYTES_DEFAULT
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        start,
   input  logic [23:0] secret_key,
   output logic [4:0]  pt_addr,
   input  logic [7:0]  pt_rdata,
   output logic [7:0]  s_addr,
   output logic [7:0]  s_wdata,
   output logic        s_wren,
   input  logic [7:0]  s_rdata,
   output logic [4:0]  ct_addr,
   output logic [7:0]  ct_wdata,
   output logic        ct_wren,
   output logic        busy,
   output logic        done
);

   localparam logic [4:0] K_LAST    = 5'(MSG_LEN - 1);
   localparam logic [1:0] KIDX_LAST = 2'(KEY_BYTES - 1);

   state_t      state_q, state_d;
   logic [7:0]  i_q, i_d;
   logic [7:0]  j_q, j_d;
   logic [4:0]  k_q, k_d;
   logic [23:0] key_q, key_d;
   logic [1:0]  kidx_q, kidx_d;
   logic [7:0]  si_q, si_d;
   logic [7:0]  sj_q, sj_d;
   logic [7:0]  pt_q, pt_d;

   logic [7:0]  j_ksa;
   logic [7:0]  j_prga;
   logic [7:0]  i_inc;

   // All index arithmetic wraps naturally at 8 bits.
   assign j_ksa  = j_q + s_rdata + key_byte(key_q, kidx_q);
   assign j_prga = j_q + s_rdata;
   assign i_inc  = i_q + 8'd1;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q <= ST_IDLE;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         key_q   <= '0;
         kidx_q  <= '0;
         si_q    <= '0;
         sj_q    <= '0;
         pt_q    <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         key_q   <= key_d;
         kidx_q  <= kidx_d;
         si_q    <= si_d;
         sj_q    <= sj_d;
         pt_q    <= pt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      i_d      = i_q;
      j_d      = j_q;
      k_d      = k_q;
      key_d    = key_q;
      kidx_d   = kidx_q;
      si_d     = si_q;
      sj_d     = sj_q;
      pt_d     = pt_q;
      pt_addr  = '0;
      s_addr   = '0;
      s_wdata  = '0;
      s_wren   = 1'b0;
      ct_addr  = '0;
      ct_wdata = '0;
      ct_wren  = 1'b0;
      busy     = 1'b1;
      done     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               key_d   = secret_key;
               i_d     = '0;
               state_d = ST_INIT;
            end
         end

         ST_INIT: begin
            s_addr  = i_q;
            s_wdata = i_q;
            s_wren  = 1'b1;
            i_d     = i_inc;
            if (i_q == 8'hFF) begin
               j_d     = '0;
               kidx_d  = '0;
               state_d = ST_KSA_RD_I;
            end
         end

         ST_KSA_RD_I: begin
            s_addr  = i_q;
            state_d = ST_KSA_GET_I;
         end

         ST_KSA_GET_I: begin
            si_d    = s_rdata;
            j_d     = j_ksa;
            s_addr  = j_ksa;
            state_d = ST_KSA_GET_J;
         end

         ST_KSA_GET_J: begin
            sj_d    = s_rdata;
            state_d = ST_KSA_WR_I;
         end

         ST_KSA_WR_I: begin
            s_addr  = i_q;
            s_wdata = sj_q;
            s_wren  = 1'b1;
            state_d = ST_KSA_WR_J;
         end

         ST_KSA_WR_J: begin
            s_addr  = j_q;
            s_wdata = si_q;
            s_wren  = 1'b1;
            i_d     = i_inc;
            kidx_d  = (kidx_q == KIDX_LAST) ? 2'd0 : kidx_q + 2'd1;
            if (i_q == 8'hFF) begin
               j_d     = '0;
               k_d     = '0;
               state_d = ST_PR_RD_I;
            end else begin
               state_d = ST_KSA_RD_I;
            end
         end

         // PRGA pre-increments i, so the first keystream byte uses s[1].
         ST_PR_RD_I: begin
            i_d     = i_inc;
            s_addr  = i_inc;
            pt_addr = k_q;
            state_d = ST_PR_GET_I;
         end

         ST_PR_GET_I: begin
            si_d    = s_rdata;
            pt_d    = pt_rdata;
            j_d     = j_prga;
            s_addr  = j_prga;
            state_d = ST_PR_GET_J;
         end

         ST_PR_GET_J: begin
            sj_d    = s_rdata;
            state_d = ST_PR_WR_I;
         end

         ST_PR_WR_I: begin
            s_addr  = i_q;
            s_wdata = sj_q;
            s_wren  = 1'b1;
            state_d = ST_PR_WR_J;
         end

         ST_PR_WR_J: begin
            s_addr  = j_q;
            s_wdata = si_q;
            s_wren  = 1'b1;
            state_d = ST_PR_RD_F;
         end

         ST_PR_RD_F: begin
            s_addr  = si_q + sj_q;
            state_d = ST_PR_GET_F;
         end

         ST_PR_GET_F: begin
            ct_addr  = k_q;
            ct_wdata = s_rdata ^ pt_q;
            ct_wren  = 1'b1;
            if (k_q == K_LAST) begin
               state_d = ST_DONE;
            end else begin
               k_d     = k_q + 5'd1;
               state_d = ST_PR_RD_I;
            end
         end

         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_rc4_encryptor.sv
// Self-checking bench for rc4_encryptor: models the three RAMs, predicts the
// ciphertext with a plain RC4 routine and checks the cycle schedule every cycle.
module tb_rc4_encryptor;

   localparam int RUN_LAST = 1760;   // run cycle index of the DONE cycle

   logic        CLOCK_50 = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [23:0] secret_key = '0;
   logic [4:0]  pt_addr;
   logic [7:0]  pt_rdata;
   logic [7:0]  s_addr;
   logic [7:0]  s_wdata;
   logic        s_wren;
   logic [7:0]  s_rdata;
   logic [4:0]  ct_addr;
   logic [7:0]  ct_wdata;
   logic        ct_wren;
   logic        busy;
   logic        done;

   rc4_encryptor dut (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .start      (start),
      .secret_key (secret_key),
      .pt_addr    (pt_addr),
      .pt_rdata   (pt_rdata),
      .s_addr     (s_addr),
      .s_wdata    (s_wdata),
      .s_wren     (s_wren),
      .s_rdata    (s_rdata),
      .ct_addr    (ct_addr),
      .ct_wdata   (ct_wdata),
      .ct_wren    (ct_wren),
      .busy       (busy),
      .done       (done)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   // RAM models, one-cycle registered read
   logic [7:0] s_mem  [256];
   logic [7:0] pt_mem [32];
   logic [7:0] ct_mem [32];

   always @(posedge CLOCK_50) begin
      if (s_wren) s_mem[s_addr] <= s_wdata;
      if (ct_wren) ct_mem[ct_addr] <= ct_wdata;
      s_rdata  <= s_mem[s_addr];
      pt_rdata <= pt_mem[pt_addr];
   end

   int n_pass  = 0;
   int n_total = 0;
   int done_cnt = 0;
   int ct_cnt   = 0;
   logic chk_en = 1'b0;

   logic [7:0] exp_ct [32];
   logic [7:0] orig   [32];
   logic [7:0] kv     [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Protocol tracker: which cycle of a run the DUT must be in.
   logic act_q = 1'b0;
   int   rc_q  = 0;

   always @(posedge CLOCK_50) begin
      if (reset) begin
         act_q <= 1'b0;
      end else if (act_q) begin
         if (rc_q == RUN_LAST) act_q <= 1'b0;
         else rc_q <= rc_q + 1;
      end else if (start) begin
         act_q <= 1'b1;
         rc_q  <= 0;
      end
   end

   // Per-cycle compare against the schedule: INIT 256, KSA 5/i, PRGA 7/byte, DONE.
   initial begin
      logic exp_s_wren, exp_ct_wren;
      int   ph, k;
      forever begin
         @(negedge CLOCK_50);
         if (chk_en) begin
            exp_s_wren  = 1'b0;
            exp_ct_wren = 1'b0;
            k = 0;
            if (act_q) begin
               if (rc_q < 256) begin
                  exp_s_wren = 1'b1;
               end else if (rc_q < 1536) begin
                  exp_s_wren = ((rc_q - 256) % 5) >= 3;
               end else if (rc_q < RUN_LAST) begin
                  ph = (rc_q - 1536) % 7;
                  exp_s_wren  = (ph == 3) || (ph == 4);
                  exp_ct_wren = (ph == 6);
                  k = (rc_q - 1536) / 7;
               end
            end
            check("busy", 32'(busy), 32'(act_q));
            check("done", 32'(done), 32'(act_q && rc_q == RUN_LAST));
            check("s_wren", 32'(s_wren), 32'(exp_s_wren));
            check("ct_wren", 32'(ct_wren), 32'(exp_ct_wren));
            if (act_q && rc_q < 256) begin
               check("init_addr", 32'(s_addr), 32'(rc_q));
               check("init_wdata", 32'(s_wdata), 32'(rc_q));
            end
            if (act_q && rc_q == 256) begin
               int bad;
               bad = 0;
               for (int x = 0; x < 256; x++) if (s_mem[x] !== 8'(x)) bad++;
               check("s_after_init_bad", 32'(bad), 32'd0);
            end
            if (exp_ct_wren && ct_wren) begin
               check("ct_addr", 32'(ct_addr), 32'(k));
               check("ct_wdata", 32'(ct_wdata), 32'(exp_ct[k]));
            end
            if (done) done_cnt++;
            if (ct_wren) ct_cnt++;
         end
      end
   end

   task automatic tick();
      @(negedge CLOCK_50);
      #1;
   endtask

   // Plain RC4 reference over pt_mem.
   task automatic model(input logic [23:0] key);
      int s [256];
      int kb [3];
      int i, j, t;
      kb[0] = int'(key[23:16]);
      kb[1] = int'(key[15:8]);
      kb[2] = int'(key[7:0]);
      for (int x = 0; x < 256; x++) s[x] = x;
      j = 0;
      for (int x = 0; x < 256; x++) begin
         j = (j + s[x] + kb[x % 3]) % 256;
         t = s[x]; s[x] = s[j]; s[j] = t;
      end
      i = 0;
      j = 0;
      for (int n = 0; n < 32; n++) begin
         i = (i + 1) % 256;
         j = (j + s[i]) % 256;
         t = s[i]; s[i] = s[j]; s[j] = t;
         exp_ct[n] = 8'(s[(s[i] + s[j]) % 256]) ^ pt_mem[n];
      end
   endtask

   // One encryption run; poke_at pulses start mid-run, abort_at resets mid-run.
   task automatic run(input string tag, input logic [23:0] key, input int poke_at, input int abort_at);
      int d0, c0, cyc;
      d0 = done_cnt;
      c0 = ct_cnt;
      secret_key = key;
      start = 1'b1;
      tick();
      start = 1'b0;
      secret_key = 24'($urandom);
      cyc = 1;
      while (done_cnt == d0 && cyc < 4000) begin
         if (cyc - 1 == abort_at) begin
            reset = 1'b1;
            tick();
            check({tag, "_abort_busy"}, 32'(busy), 32'd0);
            check({tag, "_abort_s_wren"}, 32'(s_wren), 32'd0);
            check({tag, "_abort_ct_wren"}, 32'(ct_wren), 32'd0);
            check({tag, "_abort_done"}, 32'(done), 32'd0);
            reset = 1'b0;
            tick();
            check({tag, "_abort_idle"}, 32'(busy), 32'd0);
            return;
         end
         start = (cyc - 1 == poke_at);
         tick();
         cyc++;
      end
      start = 1'b0;
      check({tag, "_done_cycle"}, 32'(cyc), 32'd1761);
      repeat (4) tick();
      check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
      check({tag, "_ct_pulses"}, 32'(ct_cnt - c0), 32'd32);
      for (int n = 0; n < 32; n++)
         check({tag, "_ct_mem"}, 32'(ct_mem[n]), 32'(exp_ct[n]));
   endtask

   task automatic random_text();
      int r;
      for (int n = 0; n < 32; n++) begin
         r = int'($urandom_range(0, 26));
         pt_mem[n] = (r == 26) ? 8'h20 : 8'(8'h61 + r);
      end
   endtask

   initial begin
      string msg;
      logic [23:0] rkey;
      int d0, cyc;
      kv = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
      for (int x = 0; x < 256; x++) s_mem[x] = 8'h00;
      for (int n = 0; n < 32; n++) ct_mem[n] = 8'h00;

      repeat (3) tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_s_wren", 32'(s_wren), 32'd0);
      check("rst_ct_wren", 32'(ct_wren), 32'd0);
      check("rst_s_addr", 32'(s_addr), 32'd0);
      check("rst_pt_addr", 32'(pt_addr), 32'd0);
      reset = 1'b0;
      tick();
      chk_en = 1'b1;

      // Known vector, model pinned by literal bytes
      msg = "Plaintext";
      for (int n = 0; n < 32; n++) pt_mem[n] = (n < 9) ? msg[n] : 8'h00;
      model(24'h4B6579);
      for (int n = 0; n < 9; n++) check("model_kv", 32'(exp_ct[n]), 32'(kv[n]));
      run("kv", 24'h4B6579, -1, -1);
      for (int n = 0; n < 9; n++) check("kv_literal", 32'(ct_mem[n]), 32'(kv[n]));

      // Round trip under key 000249
      random_text();
      for (int n = 0; n < 32; n++) orig[n] = pt_mem[n];
      model(24'h000249);
      run("rt_enc", 24'h000249, -1, -1);
      for (int n = 0; n < 32; n++) pt_mem[n] = ct_mem[n];
      model(24'h000249);
      for (int n = 0; n < 32; n++) check("model_rt", 32'(exp_ct[n]), 32'(orig[n]));
      run("rt_dec", 24'h000249, -1, -1);
      for (int n = 0; n < 32; n++) check("rt_plain", 32'(ct_mem[n]), 32'(orig[n]));

      // Random keys and data, one with a start pulse mid-run
      for (int r = 0; r < 2; r++) begin
         rkey = 24'($urandom);
         for (int n = 0; n < 32; n++) pt_mem[n] = 8'($urandom);
         model(rkey);
         run("rand", rkey, (r == 1) ? 500 : -1, -1);
      end

      // Reset during KSA, then a fresh known-vector run
      run("abort", 24'h123456, -1, 800);
      for (int n = 0; n < 32; n++) pt_mem[n] = (n < 9) ? msg[n] : 8'h00;
      model(24'h4B6579);
      run("kv_after_abort", 24'h4B6579, -1, -1);

      // start held high through DONE restarts immediately
      d0 = done_cnt;
      secret_key = 24'h4B6579;
      start = 1'b1;
      cyc = 0;
      while (done_cnt - d0 < 1 && cyc < 4000) begin tick(); cyc++; end
      tick();
      tick();
      check("restart_busy", 32'(busy), 32'd1);
      start = 1'b0;
      while (done_cnt - d0 < 2 && cyc < 8000) begin tick(); cyc++; end
      check("restart_done_pulses", 32'(done_cnt - d0), 32'd2);
      repeat (4) tick();
      for (int n = 0; n < 9; n++) check("restart_kv", 32'(ct_mem[n]), 32'(kv[n]));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
